// File: rtl/phase_step_config_writer_pkg.sv
// Shared definitions for the synth configuration writers.
//   NUM_VOPS           : number of addressable voice operators
//   VoiceOperatorID_t  : voice-operator index type
//   CMD_PHASE_STEP     : command byte selecting the phase step table
//   ConfigWriterState_t: packet parser / strobe generator states
`ifndef NUM_VOICE_OPERATORS
`define NUM_VOICE_OPERATORS 32
`endif

package phase_step_config_writer_pkg;

  localparam int NUM_VOPS = `NUM_VOICE_OPERATORS;
  localparam int VOP_ID_W = (NUM_VOPS > 1) ? $clog2(NUM_VOPS) : 1;

  typedef logic [VOP_ID_W-1:0] VoiceOperatorID_t;

  // Command codes; later config targets (algorithm words, envelopes) add theirs here.
  localparam logic [7:0] CMD_PHASE_STEP = 8'h01;

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DHI     = 3'd2,
    ST_DLO     = 3'd3,
    ST_WR_HI   = 3'd4,
    ST_WR_LO   = 3'd5,
    ST_DISCARD = 3'd6
  } ConfigWriterState_t;

  // The address byte is compared at full 8-bit width before it is narrowed.
  function automatic logic addr_in_range(input logic [7:0] addr_byte);
    return int'(addr_byte) < NUM_VOPS;
  endfunction

endpackage

// File: rtl/phase_step_config_writer.sv
// Parses 4-byte host packets {CMD, ADDR, DATA_HI, DATA_LO} and issues the
// two byte-lane write strobes that load one 16-bit phase step.
// Ports:
//   i_Clock, i_Reset_n             : clock, synchronous active-low reset
//   i_FrameStart                   : chip-select pulse, resynchronises the parser
//   i_ByteValid/i_ByteData         : host byte stream
//   o_ByteReady                    : byte accepted when valid && ready
//   o_PhaseStepConfigWriteEnable   : bit0 = high byte lane, bit1 = low byte lane
//   o_PhaseStepConfigWriteAddr     : target voice operator
//   o_PhaseStepConfigWriteData     : byte for the enabled lane
//   i_ClearError / o_Error         : sticky bad-command / bad-address flag
//   o_Busy                         : parser is mid-packet or writing
module phase_step_config_writer
  import phase_step_config_writer_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_FrameStart,
  input  logic             i_ByteValid,
  input  logic [7:0]       i_ByteData,
  output logic             o_ByteReady,
  output logic [1:0]       o_PhaseStepConfigWriteEnable,
  output VoiceOperatorID_t o_PhaseStepConfigWriteAddr,
  output logic [7:0]       o_PhaseStepConfigWriteData,
  input  logic             i_ClearError,
  output logic             o_Error,
  output logic             o_Busy
);

  ConfigWriterState_t state_q, state_d;
  ConfigWriterState_t parse_state;
  logic [1:0]         cnt_q, cnt_d;      // bytes left to discard
  VoiceOperatorID_t   addr_q, addr_d;    // address of the packet in flight
  logic [7:0]         dhi_q, dhi_d;
  logic [7:0]         dlo_q, dlo_d;
  logic [1:0]         we_q, we_d;
  VoiceOperatorID_t   waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               accept;
  logic               err_set;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dhi_d   = dhi_q;
    dlo_d   = dlo_q;
    we_d    = 2'b00;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_set = 1'b0;
    accept  = i_ByteValid && ready_q;

    // A frame start outside the write pair aborts the partial packet; a byte
    // accepted in the same cycle is parsed as the new packet's CMD byte.
    // During WR_HI/WR_LO the pulse is moot: the pair always returns to CMD.
    parse_state = state_q;
    if (i_FrameStart && state_q != ST_WR_HI && state_q != ST_WR_LO) begin
      parse_state = ST_CMD;
      state_d     = ST_CMD;
    end

    unique case (parse_state)
      ST_CMD: begin
        if (accept) begin
          if (i_ByteData == CMD_PHASE_STEP) begin
            state_d = ST_ADDR;
          end else begin
            err_set = 1'b1;
            state_d = ST_DISCARD;
            cnt_d   = 2'd3;
          end
        end
      end
      ST_ADDR: begin
        if (accept) begin
          if (addr_in_range(i_ByteData)) begin
            addr_d  = VoiceOperatorID_t'(i_ByteData);
            state_d = ST_DHI;
          end else begin
            err_set = 1'b1;
            state_d = ST_DISCARD;
            cnt_d   = 2'd2;
          end
        end
      end
      ST_DHI: begin
        if (accept) begin
          dhi_d   = i_ByteData;
          state_d = ST_DLO;
        end
      end
      ST_DLO: begin
        if (accept) begin
          dlo_d   = i_ByteData;
          state_d = ST_WR_HI;
          we_d    = 2'b01;
          waddr_d = addr_q;
          wdata_d = dhi_q;
        end
      end
      ST_WR_HI: begin
        state_d = ST_WR_LO;
        we_d    = 2'b10;
        wdata_d = dlo_q;
      end
      ST_WR_LO: begin
        state_d = ST_CMD;
      end
      ST_DISCARD: begin
        if (accept) begin
          cnt_d = 2'(cnt_q - 2'd1);
          if (cnt_q == 2'd1) begin
            state_d = ST_CMD;
          end
        end
      end
      default: begin
        state_d = ST_CMD;
      end
    endcase

    // Setting wins over clearing in the same cycle.
    err_d   = err_set || (err_q && !i_ClearError);
    ready_d = (state_d != ST_WR_HI) && (state_d != ST_WR_LO);
    busy_d  = (state_d != ST_CMD);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above. The reset is synchronous, so it lives
  // inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q <= ST_CMD;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      dhi_q   <= 8'h00;
      dlo_q   <= 8'h00;
      we_q    <= 2'b00;
      waddr_q <= '0;
      wdata_q <= 8'h00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign o_ByteReady                  = ready_q;
  assign o_PhaseStepConfigWriteEnable = we_q;
  assign o_PhaseStepConfigWriteAddr   = waddr_q;
  assign o_PhaseStepConfigWriteData   = wdata_q;
  assign o_Error                      = err_q;
  assign o_Busy                       = busy_q;

endmodule

// File: tb/tb_phase_step_config_writer.sv
// Cycle-by-cycle directed vectors for phase_step_config_writer. Each record
// holds the inputs for one clock edge and the outputs expected just after it.
module tb_phase_step_config_writer;
  import phase_step_config_writer_pkg::*;

  localparam logic F = 1'b0;
  localparam logic T = 1'b1;
  localparam logic [7:0] ADDR_BAD = 8'(NUM_VOPS);
  localparam logic [7:0] ADDR_MAX = 8'(NUM_VOPS - 1);

  typedef struct {
    logic       rst;
    logic       fs;
    logic       v;
    logic [7:0] d;
    logic       clr;
    logic [1:0] we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       rdy;
    logic       err;
    logic       busy;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic [1:0]       we;
  VoiceOperatorID_t waddr;
  logic [7:0]       wdata;
  logic             clear_error;
  logic             error;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  phase_step_config_writer dut (
    .i_Clock                      (clk),
    .i_Reset_n                    (rst_n),
    .i_FrameStart                 (frame_start),
    .i_ByteValid                  (byte_valid),
    .i_ByteData                   (byte_data),
    .o_ByteReady                  (byte_ready),
    .o_PhaseStepConfigWriteEnable (we),
    .o_PhaseStepConfigWriteAddr   (waddr),
    .o_PhaseStepConfigWriteData   (wdata),
    .i_ClearError                 (clear_error),
    .o_Error                      (error),
    .o_Busy                       (busy)
  );

  function automatic vec_t mk(input logic rst, input logic fs, input logic v,
                              input logic [7:0] d, input logic clr,
                              input logic [1:0] e_we, input logic [7:0] e_addr,
                              input logic [7:0] e_data, input logic e_rdy,
                              input logic e_err, input logic e_busy);
    vec_t r;
    r.rst = rst; r.fs = fs; r.v = v; r.d = d; r.clr = clr;
    r.we = e_we; r.addr = e_addr; r.data = e_data;
    r.rdy = e_rdy; r.err = e_err; r.busy = e_busy;
    return r;
  endfunction

  task automatic check(input string name, input logic [1:0] e_we,
                       input logic [7:0] e_addr, input logic [7:0] e_data,
                       input logic e_rdy, input logic e_err, input logic e_busy);
    logic [20:0] act, exp;
    act = {we, 8'(waddr), wdata, byte_ready, error, busy};
    exp = {e_we, e_addr, e_data, e_rdy, e_err, e_busy};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got we=%b addr=%h data=%h rdy=%b err=%b busy=%b, expected we=%b addr=%h data=%h rdy=%b err=%b busy=%b",
               name, we, 8'(waddr), wdata, byte_ready, error, busy,
               e_we, e_addr, e_data, e_rdy, e_err, e_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; byte_valid = 1'b0;
    byte_data = 8'h00; clear_error = 1'b0;

    // Good packet, valid held high through the write pair.
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h00,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'h05,F, 2'b00,8'h00,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'h12,F, 2'b00,8'h00,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'h34,F, 2'b01,8'h05,8'h12, F,F,T));
    tbl.push_back(mk(F,F,T,8'h7F,F, 2'b10,8'h05,8'h34, F,F,T));
    tbl.push_back(mk(F,F,T,8'h7F,F, 2'b00,8'h05,8'h34, T,F,F));
    // Bad command: three bytes discarded, then a good packet.
    tbl.push_back(mk(F,F,T,8'h7F,F, 2'b00,8'h05,8'h34, T,T,T));
    tbl.push_back(mk(F,F,T,8'h05,F, 2'b00,8'h05,8'h34, T,T,T));
    tbl.push_back(mk(F,F,T,8'h12,F, 2'b00,8'h05,8'h34, T,T,T));
    tbl.push_back(mk(F,F,T,8'h34,F, 2'b00,8'h05,8'h34, T,T,F));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h05,8'h34, T,T,T));
    tbl.push_back(mk(F,F,T,8'h03,F, 2'b00,8'h05,8'h34, T,T,T));
    tbl.push_back(mk(F,F,T,8'hAB,F, 2'b00,8'h05,8'h34, T,T,T));
    tbl.push_back(mk(F,F,T,8'hCD,F, 2'b01,8'h03,8'hAB, F,T,T));
    tbl.push_back(mk(F,F,F,8'h00,F, 2'b10,8'h03,8'hCD, F,T,T));
    tbl.push_back(mk(F,F,F,8'h00,F, 2'b00,8'h03,8'hCD, T,T,F));
    tbl.push_back(mk(F,F,F,8'h00,T, 2'b00,8'h03,8'hCD, T,F,F));
    // Out-of-range address with a coincident clear (set wins), two bytes discarded.
    tbl.push_back(mk(F,F,T,8'h01,F,     2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,F,T,ADDR_BAD,T,  2'b00,8'h03,8'hCD, T,T,T));
    tbl.push_back(mk(F,F,T,8'h00,F,     2'b00,8'h03,8'hCD, T,T,T));
    tbl.push_back(mk(F,F,T,8'h00,F,     2'b00,8'h03,8'hCD, T,T,F));
    tbl.push_back(mk(F,F,F,8'h00,T,     2'b00,8'h03,8'hCD, T,F,F));
    // Frame start coincident with a byte restarts the packet with it as CMD;
    // frame start during WR_LO neither blocks the pair nor accepts a byte.
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,F,T,8'h05,F, 2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,F,T,8'h12,F, 2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,T,T,8'h01,F, 2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,F,T,8'h02,F, 2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,F,T,8'h56,F, 2'b00,8'h03,8'hCD, T,F,T));
    tbl.push_back(mk(F,F,T,8'h78,F, 2'b01,8'h02,8'h56, F,F,T));
    tbl.push_back(mk(F,F,F,8'h00,F, 2'b10,8'h02,8'h78, F,F,T));
    tbl.push_back(mk(F,T,T,8'h01,F, 2'b00,8'h02,8'h78, T,F,F));
    // Two packets streamed with valid always high: pairs 6 cycles apart.
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h02,8'h78, T,F,T));
    tbl.push_back(mk(F,F,T,8'h00,F, 2'b00,8'h02,8'h78, T,F,T));
    tbl.push_back(mk(F,F,T,8'h00,F, 2'b00,8'h02,8'h78, T,F,T));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b01,8'h00,8'h00, F,F,T));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b10,8'h00,8'h01, F,F,T));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h00,8'h01, T,F,F));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h00,8'h01, T,F,T));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h00,8'h01, T,F,T));
    tbl.push_back(mk(F,F,T,8'hFF,F, 2'b00,8'h00,8'h01, T,F,T));
    tbl.push_back(mk(F,F,T,8'hFF,F, 2'b01,8'h01,8'hFF, F,F,T));
    tbl.push_back(mk(F,F,T,8'hFF,F, 2'b10,8'h01,8'hFF, F,F,T));
    tbl.push_back(mk(F,F,F,8'h00,F, 2'b00,8'h01,8'hFF, T,F,F));
    // Highest valid address is accepted.
    tbl.push_back(mk(F,F,T,8'h01,F,    2'b00,8'h01,8'hFF, T,F,T));
    tbl.push_back(mk(F,F,T,ADDR_MAX,F, 2'b00,8'h01,8'hFF, T,F,T));
    tbl.push_back(mk(F,F,T,8'h00,F,    2'b00,8'h01,8'hFF, T,F,T));
    tbl.push_back(mk(F,F,T,8'h00,F,    2'b01,ADDR_MAX,8'h00, F,F,T));
    tbl.push_back(mk(F,F,F,8'h00,F,    2'b10,ADDR_MAX,8'h00, F,F,T));
    tbl.push_back(mk(F,F,F,8'h00,F,    2'b00,ADDR_MAX,8'h00, T,F,F));
    // Reset while in DHI discards the partial packet.
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,ADDR_MAX,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'h05,F, 2'b00,ADDR_MAX,8'h00, T,F,T));
    tbl.push_back(mk(T,F,T,8'h12,F, 2'b00,8'h00,8'h00, T,F,F));
    tbl.push_back(mk(F,F,T,8'h01,F, 2'b00,8'h00,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'h04,F, 2'b00,8'h00,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'hAA,F, 2'b00,8'h00,8'h00, T,F,T));
    tbl.push_back(mk(F,F,T,8'h55,F, 2'b01,8'h04,8'hAA, F,F,T));
    tbl.push_back(mk(F,F,F,8'h00,F, 2'b10,8'h04,8'h55, F,F,T));
    tbl.push_back(mk(F,F,F,8'h00,F, 2'b00,8'h04,8'h55, T,F,F));
    // Frame start aborts DISCARD; error stays until cleared.
    tbl.push_back(mk(F,F,T,8'h7F,F, 2'b00,8'h04,8'h55, T,T,T));
    tbl.push_back(mk(F,T,F,8'h00,F, 2'b00,8'h04,8'h55, T,T,F));
    tbl.push_back(mk(F,F,F,8'h00,T, 2'b00,8'h04,8'h55, T,F,F));

    repeat (2) @(posedge clk);
    #1;
    check("reset", 2'b00, 8'h00, 8'h00, T, F, F);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n       = !tbl[i].rst;
      frame_start = tbl[i].fs;
      byte_valid  = tbl[i].v;
      byte_data   = tbl[i].d;
      clear_error = tbl[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].data,
            tbl[i].rdy, tbl[i].err, tbl[i].busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
